// File: rtl/snes_pad_reader_pkg.sv
// Shared definitions for the SNES pad poller: FSM encoding, default timing
// constants and the button bit positions in the published word.
package snes_pad_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_GAP,
        ST_CLK_LO,
        ST_CLK_HI,
        ST_DONE
    } state_t;

    localparam int DEFAULT_DIV         = 300;
    localparam int DEFAULT_POLL_CYCLES = 833333;
    localparam int NUM_BITS            = 16;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

endpackage

// File: rtl/snes_pad_reader_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs; resets to all ones
// so idle-high lines do not read as active while reset is held.
module sync_2ff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/snes_pad_reader.sv
// Autonomous SNES pad poller: latches the pad, clocks out 16 serial bits and
// publishes them as an active-high button word with a one-cycle strobe.
module snes_pad_reader
    import snes_pad_reader_pkg::*;
#(
    parameter int DIV         = DEFAULT_DIV,
    parameter int POLL_CYCLES = DEFAULT_POLL_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        nesd,
    output logic        nesc,
    output logic        nesl,
    output logic [15:0] nesState,
    output logic        nesValid
);

    localparam int DUR_W  = $clog2(2 * DIV);
    localparam int POLL_W = $clog2(POLL_CYCLES);

    state_t              state, state_next;
    logic [DUR_W-1:0]    dur_q;
    logic [POLL_W-1:0]   poll_q;
    logic [3:0]          bit_q;
    logic [NUM_BITS-1:0] shift_q;
    logic                nesd_sync;
    logic                dur_last;
    logic                sample_bit;

    sync_2ff #(.WIDTH(1), .RESET_VALUE(1'b1)) u_sync_nesd (
        .clk   (clk),
        .reset (reset),
        .d     (nesd),
        .q     (nesd_sync)
    );

    assign dur_last = (dur_q == '0);

    function automatic logic [DUR_W-1:0] dur_load(input state_t s);
        case (s)
            ST_LATCH:                     return DUR_W'(2 * DIV - 1);
            ST_GAP, ST_CLK_LO, ST_CLK_HI: return DUR_W'(DIV - 1);
            default:                      return '0;
        endcase
    endfunction

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        sample_bit = 1'b0;
        case (state)
            ST_IDLE:   if (poll_q == '0) state_next = ST_LATCH;
            ST_LATCH:  if (dur_last) state_next = ST_GAP;
            ST_GAP: begin
                if (dur_last) begin
                    state_next = ST_CLK_LO;
                    sample_bit = 1'b1;
                end
            end
            ST_CLK_LO: if (dur_last) state_next = ST_CLK_HI;
            ST_CLK_HI: begin
                if (dur_last) begin
                    if (bit_q == 4'd15) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_CLK_LO;
                        sample_bit = 1'b1;
                    end
                end
            end
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Pin outputs and the strobe are registered from the next state so they
    // line up with the state they belong to and never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            dur_q    <= '0;
            poll_q   <= '0;
            bit_q    <= '0;
            // NOTE: the shift register is cleared on reset so a mid-frame reset
            // leaves no stale bits, even though each frame overwrites all 16.
            shift_q  <= '0;
            nesState <= '0;
            nesValid <= 1'b0;
            nesc     <= 1'b1;
            nesl     <= 1'b0;
        end else begin
            state  <= state_next;
            poll_q <= (poll_q == POLL_W'(POLL_CYCLES - 1)) ? '0 : poll_q + 1'b1;

            if (state_next != state) begin
                dur_q <= dur_load(state_next);
            end else if (!dur_last) begin
                dur_q <= dur_q - 1'b1;
            end

            if (sample_bit) begin
                if (state == ST_GAP) begin
                    shift_q[0] <= ~nesd_sync;
                    bit_q      <= '0;
                end else begin
                    shift_q[bit_q + 4'd1] <= ~nesd_sync;
                    bit_q                 <= bit_q + 4'd1;
                end
            end

            if (state_next == ST_DONE) begin
                nesState <= shift_q;
            end
            nesValid <= (state_next == ST_DONE);
            nesl     <= (state_next == ST_LATCH);
            nesc     <= (state_next != ST_CLK_LO);
        end
    end

endmodule
